// File: rtl/int_alu_core.sv
// Integer ALU core: registered add-with-carry and AND, plus a multi-cycle restoring
// divider, sharing one start/busy/done handshake and one set of result registers.
module int_alu_core #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    DONE   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_carry_out;
  logic             r_div_by_zero;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_partial;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_b_zero;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic             w_ge;
  logic [WIDTH-1:0] w_partial_next;
  logic [WIDTH-1:0] w_dq_next;

  assign w_accept = (r_state == IDLE) && start;
  assign w_b_zero = (b == '0);
  assign w_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

  // One restoring step: the true difference is below 2^WIDTH whenever w_ge holds,
  // so a WIDTH-wide subtraction is exact.
  assign w_shifted      = {r_partial, r_dq[WIDTH-1]};
  assign w_ge           = (w_shifted >= {1'b0, r_divisor});
  assign w_partial_next = w_ge ? (w_shifted[WIDTH-1:0] - r_divisor) : w_shifted[WIDTH-1:0];
  assign w_dq_next      = {r_dq[WIDTH-2:0], w_ge};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the next-state default is assigned first so no path through the case
  // leaves w_next_state unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((op_t'(op_sel) == OP_DIV) && !w_b_zero) w_next_state = DIVIDE;
          else                                       w_next_state = DONE;
        end
      end
      DIVIDE:  if (r_count == CNT_LAST) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_result      <= '0;
      r_remainder   <= '0;
      r_carry_out   <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_dq          <= '0;
      r_divisor     <= '0;
      r_partial     <= '0;
      r_count       <= '0;
    end else if (w_accept) begin
      case (op_t'(op_sel))
        OP_ADD: begin
          {r_carry_out, r_result} <= w_sum;
          r_remainder             <= '0;
          r_div_by_zero           <= 1'b0;
        end
        OP_AND: begin
          r_result      <= a & b;
          r_remainder   <= '0;
          r_carry_out   <= 1'b0;
          r_div_by_zero <= 1'b0;
        end
        OP_DIV: begin
          if (w_b_zero) begin
            r_result      <= '1;
            r_remainder   <= a;
            r_carry_out   <= 1'b0;
            r_div_by_zero <= 1'b1;
          end else begin
            // Visible outputs keep their old values until the quotient is complete.
            r_dq      <= a;
            r_divisor <= b;
            r_partial <= '0;
            r_count   <= CNT_INIT;
          end
        end
        default: begin
          r_result      <= '0;
          r_remainder   <= '0;
          r_carry_out   <= 1'b0;
          r_div_by_zero <= 1'b0;
        end
      endcase
    end else if (r_state == DIVIDE) begin
      r_dq      <= w_dq_next;
      r_partial <= w_partial_next;
      r_count   <= r_count - CNT_LAST;
      if (r_count == CNT_LAST) begin
        r_result      <= w_dq_next;
        r_remainder   <= w_partial_next;
        r_carry_out   <= 1'b0;
        r_div_by_zero <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign remainder   = r_remainder;
  assign carry_out   = r_carry_out;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_int_alu_core.sv
// Directed bench for int_alu_core (WIDTH=4): add, AND, divide, divide-by-zero,
// busy-time start rejection and asynchronous abort, with hand-computed expectations.
module tb_int_alu_core;

  localparam int WIDTH = 4;

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             carry_out;
  logic             div_by_zero;

  int n_assert;
  int n_fail;

  int_alu_core #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op_sel      (op_sel),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .remainder   (remainder),
    .carry_out   (carry_out),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] res, input logic [3:0] rem,
                               input logic cout, input logic dbz);
    check({tag, ".result"},      32'(result),      32'(res));
    check({tag, ".remainder"},   32'(remainder),   32'(rem));
    check({tag, ".carry_out"},   32'(carry_out),   32'(cout));
    check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(dbz));
  endtask

  // Called at a negedge: present one start strobe, end at the negedge after edge T0.
  task automatic launch(input logic [1:0] op, input logic [3:0] va, input logic [3:0] vb,
                        input logic cin);
    start    = 1'b1;
    op_sel   = op;
    a        = va;
    b        = vb;
    carry_in = cin;
    @(negedge clock);
    start    = 1'b0;
    a        = ~va;
    b        = ~vb;
    carry_in = ~cin;
  endtask

  // Counts negedges after T0 until done; the bound is treated as a failure.
  task automatic wait_done(input string tag, input int expected_cycles);
    int cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(expected_cycles));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    op_sel   = 2'b00;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;

    // 1. Reset, then add.
    repeat (2) @(negedge clock);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check_outputs("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    launch(2'b00, 4'b0001, 4'b1110, 1'b0);
    check("add1.done", 32'(done), 32'd1);
    check_outputs("add1", 4'b1111, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    check("add1.idle", 32'(busy), 32'd0);

    launch(2'b00, 4'b1111, 4'b1111, 1'b1);
    check("add2.done", 32'(done), 32'd1);
    check_outputs("add2", 4'b1111, 4'b0000, 1'b1, 1'b0);
    @(negedge clock);

    // 2. AND.
    launch(2'b01, 4'b1100, 4'b0011, 1'b1);
    check("and1.done", 32'(done), 32'd1);
    check_outputs("and1", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);

    launch(2'b01, 4'b1111, 4'b1010, 1'b0);
    check("and2.done", 32'(done), 32'd1);
    check_outputs("and2", 4'b1010, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);

    // 3. Divide: 13/3 = 4 r1, busy across five cycles with done in the fifth.
    launch(2'b10, 4'b1101, 4'b0011, 1'b0);
    check("div1.busy", 32'(busy), 32'd1);
    check("div1.early_done", 32'(done), 32'd0);
    check("div1.hold", 32'(result), 32'b1010);
    wait_done("div1", 5);
    check("div1.busy_done", 32'(busy), 32'd1);
    check_outputs("div1", 4'b0100, 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    check("div1.idle", 32'(busy), 32'd0);

    launch(2'b10, 4'b0010, 4'b0111, 1'b0);
    wait_done("div2", 5);
    check_outputs("div2", 4'b0000, 4'b0010, 1'b0, 1'b0);
    @(negedge clock);

    launch(2'b10, 4'b1111, 4'b0001, 1'b0);
    wait_done("div3", 5);
    check_outputs("div3", 4'b1111, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);

    // 4. Divide by zero.
    launch(2'b10, 4'b1001, 4'b0000, 1'b0);
    check("dbz.done", 32'(done), 32'd1);
    check_outputs("dbz", 4'b1111, 4'b1001, 1'b0, 1'b1);
    @(negedge clock);

    // 5a. Start during DIVIDE is ignored.
    launch(2'b10, 4'b1101, 4'b0011, 1'b0);
    launch(2'b00, 4'b0001, 4'b0001, 1'b0);
    wait_done("ign", 4);
    check_outputs("ign", 4'b0100, 4'b0001, 1'b0, 1'b0);
    @(negedge clock);
    check("ign.no_queue", 32'(busy), 32'd0);
    @(negedge clock);
    check("ign.still_idle", 32'(busy), 32'd0);

    // 5b. Reset mid-division aborts asynchronously.
    launch(2'b10, 4'b1111, 4'b0001, 1'b0);
    @(negedge clock);
    check("abort.pre_busy", 32'(busy), 32'd1);
    check("abort.pre_hold", 32'(result), 32'b0100);
    #2 reset = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check_outputs("abort", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    check("abort.no_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 5c. Normal add after abort.
    launch(2'b00, 4'b0110, 4'b0111, 1'b1);
    check("post.done", 32'(done), 32'd1);
    check_outputs("post", 4'b1110, 4'b0000, 1'b0, 1'b0);
    @(negedge clock);
    check("post.idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
